// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - time-multiplexed 4-digit 7-segment scan driver with blanking gap
// Optional colon blink on the sel=01 slot when COLON_BLINK_EN is defined.
module digit_scan_driver #(
  parameter int DIGIT_TICKS  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_in,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_MAX = (DIGIT_TICKS > BLANK_CYCLES) ? DIGIT_TICKS : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  if (DIGIT_TICKS < 1) begin : g_bad_digit_ticks
    $error("DIGIT_TICKS must be >= 1");
  end
  if (BLANK_CYCLES < 2) begin : g_bad_blank_cycles
    $error("BLANK_CYCLES must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("BLINK_FRAMES must be >= 1");
  end

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic [6:0]    w_seg_dec;
  logic [3:0]    w_an_dec;
  logic          w_load;
  logic          w_slot_end;

  always_comb begin
    w_seg_dec = 7'h3F;
    case (digit_in)
      4'd0:    w_seg_dec = 7'h40;
      4'd1:    w_seg_dec = 7'h79;
      4'd2:    w_seg_dec = 7'h24;
      4'd3:    w_seg_dec = 7'h30;
      4'd4:    w_seg_dec = 7'h19;
      4'd5:    w_seg_dec = 7'h12;
      4'd6:    w_seg_dec = 7'h02;
      4'd7:    w_seg_dec = 7'h78;
      4'd8:    w_seg_dec = 7'h00;
      4'd9:    w_seg_dec = 7'h10;
      4'd10:   w_seg_dec = 7'h7F;
      default: w_seg_dec = 7'h3F;
    endcase
  end

  assign w_an_dec   = ~(4'b0001 << r_sel);
  assign w_load     = en && (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
  assign w_slot_end = en && (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);

  // digit_in is only captured at the last BLANK cycle, after sel has settled through the mux
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_sel   <= 2'b00;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
    end else if (!en) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_an    <= 4'hF;
    end else if (r_state == ST_BLANK) begin
      if (w_load) begin
        r_state <= ST_SHOW;
        r_cnt   <= '0;
        r_an    <= w_an_dec;
        r_seg   <= w_seg_dec;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      if (w_slot_end) begin
        r_state <= ST_BLANK;
        r_cnt   <= '0;
        r_an    <= 4'hF;
        r_sel   <= r_sel + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

`ifdef COLON_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);

  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic          r_dp;

  // a frame completes when the last slot ends and sel wraps back to 00
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
      r_blink <= 1'b0;
      r_dp    <= 1'b1;
    end else begin
      if (w_slot_end && (r_sel == 2'd3)) begin
        if (r_frame == FRAME_LAST) begin
          r_frame <= '0;
          r_blink <= ~r_blink;
        end else begin
          r_frame <= r_frame + FRAME_ONE;
        end
      end
      if (w_load) begin
        r_dp <= (r_sel == 2'd1) ? ~r_blink : 1'b1;
      end
    end
  end

  assign dp = r_dp;
`else
  assign dp = 1'b1;
`endif

  assign sel = r_sel;
  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb/tb_digit_scan_driver.sv - scoreboard bench for digit_scan_driver with random mux data and en/rst drops
// Honours COLON_BLINK_EN for the expected colon behaviour.
module tb_digit_scan_driver;

  localparam int DT = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int P  = DT + BC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] digit_in;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [3:0] mem [4];
  assign digit_in = mem[sel];

  digit_scan_driver #(.DIGIT_TICKS(DT), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .en(en), .digit_in(digit_in),
    .sel(sel), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         cyc;
    int         dur;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;  4'd10: return 7'h7F;
      default: return 7'h3F;
    endcase
  endfunction

  // slot position p counts slots since reset: sel = p mod 4, frame = p / 4
  function automatic logic dp_of(input int p);
`ifdef COLON_BLINK_EN
    int blink;
    blink = ((p / 4) / BF) % 2;
    return ((p % 4) == 1) ? (blink == 0) : 1'b1;
`else
    return (p >= 0);
`endif
  endfunction

  // monitor: pops one expectation per lit interval
  logic [3:0] prev_an  = 4'hF;
  logic [1:0] prev_sel = 2'b00;
  exp_t       cur;
  bit         cur_valid = 0;
  int         lit_len = 0;
  logic [3:0] lit_an;
  logic [6:0] lit_seg;
  logic       lit_dp;
  bit         stable;

  always @(negedge clk) begin
    if (started) begin
      if (sel !== prev_sel) begin
        n_checks++;
        if (an !== 4'hF) begin
          n_fail++;
          $display("FAIL ghost: sel %0d->%0d at cyc %0d with an=%b, required an=1111", prev_sel, sel, cyc, an);
        end
      end
      if (an !== 4'hF && prev_an === 4'hF) begin
        lit_len = 1; lit_an = an; lit_seg = seg; lit_dp = dp; stable = 1;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          cur_valid = 0;
          $display("FAIL unexpected_lit: an=%b seg=%h at cyc %0d, required no lit slot", an, seg, cyc);
        end else begin
          cur = q.pop_front();
          cur_valid = 1;
          if (an !== cur.an || seg !== cur.seg || dp !== cur.dp || sel !== cur.sel || cyc != cur.cyc) begin
            n_fail++;
            $display("FAIL slot: got sel=%0d an=%b seg=%h dp=%b cyc=%0d, required sel=%0d an=%b seg=%h dp=%b cyc=%0d",
                     sel, an, seg, dp, cyc, cur.sel, cur.an, cur.seg, cur.dp, cur.cyc);
          end
        end
      end else if (an !== 4'hF) begin
        lit_len++;
        if (an !== lit_an || seg !== lit_seg || dp !== lit_dp) stable = 0;
      end else if (prev_an !== 4'hF && cur_valid) begin
        n_checks++;
        cur_valid = 0;
        if (lit_len != cur.dur || !stable) begin
          n_fail++;
          $display("FAIL lit_span: got %0d cycles stable=%0d, required %0d cycles stable=1", lit_len, stable, cur.dur);
        end
      end
    end
    prev_an  = an;
    prev_sel = sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  int pos = 0;

  // run L enabled edges from a BLANK/cnt=0 start, then end with an en drop (kind 0) or a reset (kind 1)
  task automatic run_seg(input int L, input int kind);
    int c0, n, k, p, s, off;
    exp_t e;
    c0 = cyc;
    rst = 1'b0;
    en  = 1'b1;
    for (n = 1; n <= L; n++) begin
      if (n >= BC && ((n - BC) % P) == 0) begin
        k = (n - BC) / P;
        p = pos + k;
        s = p % 4;
        off = (n + DT < L + 1) ? n + DT : L + 1;
        e.sel = 2'(s);
        e.an  = ~(4'b0001 << s);
        e.seg = seg_of(mem[s]);
        e.dp  = dp_of(p);
        e.cyc = c0 + n;
        e.dur = off - n;
        q.push_back(e);
      end else if ($urandom_range(0, 2) == 0) begin
        mem[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      end
      tick();
    end
    pos = pos + L / P;
    if (kind == 0) begin
      en = 1'b0;
      tick();
      check("en_drop_an", int'(an), 15);
      check("en_drop_sel", int'(sel), pos % 4);
      repeat ($urandom_range(0, 4)) begin
        mem[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
        tick();
        check("en_hold_an", int'(an), 15);
        check("en_hold_sel", int'(sel), pos % 4);
      end
    end else begin
      rst = 1'b1;
      en  = 1'($urandom_range(0, 1));
      tick();
      check("rst_sel", int'(sel), 0);
      check("rst_an", int'(an), 15);
      check("rst_seg", int'(seg), 'h7F);
      check("rst_dp", int'(dp), 1);
      pos = 0;
      rst = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom_range(0, 15));
    rst = 1'b1;
    en  = 1'b1;
    tick();
    check("reset_sel", int'(sel), 0);
    check("reset_an", int'(an), 15);
    check("reset_seg", int'(seg), 'h7F);
    check("reset_dp", int'(dp), 1);
    started = 1;
    run_seg(170, 0);
    for (int s = 0; s < 30; s++) begin
      run_seg($urandom_range(1, 130), $urandom_range(0, 1));
    end
    repeat (3) tick();
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
